// File: rtl/ct_f_spsram_pkg.sv
// Shared types and helpers for the parametrised single-port SRAM.
// The CT_F_SPSRAM_OREG_EN macro selects the read latency.
package ct_f_spsram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } spsram_state_e;

   function automatic int unsigned num_slices(int unsigned dw, int unsigned sw);
      return (dw + sw - 1) / sw;
   endfunction

   // Top slice is clipped to the word width, so it may be narrower.
   function automatic int unsigned slice_msb(int unsigned k, int unsigned dw, int unsigned sw);
      int unsigned hi;
      hi = (k + 1) * sw;
      return ((hi < dw) ? hi : dw) - 1;
   endfunction

`ifdef CT_F_SPSRAM_OREG_EN
   localparam int unsigned RD_LATENCY = 2;
`else
   localparam int unsigned RD_LATENCY = 1;
`endif

endpackage

// File: rtl/ct_f_spsram_param_if.sv
// Macro-style SRAM bus: CEN/GWEN/bit-WEN access plus clear request/busy.
interface ct_f_spsram_param_if #(
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned DATA_WIDTH = 59
);
   logic [ADDR_WIDTH-1:0] A;
   logic                  CEN;
   logic                  GWEN;
   logic [DATA_WIDTH-1:0] WEN;
   logic [DATA_WIDTH-1:0] D;
   logic                  INIT_REQ;
   logic [DATA_WIDTH-1:0] Q;
   logic                  INIT_BUSY;

   modport master (
      output A, CEN, GWEN, WEN, D, INIT_REQ,
      input  Q, INIT_BUSY
   );

   modport slave (
      input  A, CEN, GWEN, WEN, D, INIT_REQ,
      output Q, INIT_BUSY
   );
endinterface

// File: rtl/ct_f_spsram_slice.sv
// One RAM slice: write-enable decode, clear/user data mux and storage.
module ct_f_spsram_slice #(
   parameter int unsigned       ADDR_WIDTH = 9,
   parameter int unsigned       WIDTH      = 29,
   parameter logic [WIDTH-1:0]  INIT_VALUE = '0
) (
   input  logic                  clk_i,
   input  logic                  clr_i,
   input  logic [ADDR_WIDTH-1:0] clr_addr_i,
   input  logic                  user_en_i,
   input  logic                  cen_i,
   input  logic                  gwen_i,
   input  logic                  wen_msb_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [WIDTH-1:0]      d_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [WIDTH-1:0]      q_o
);

   logic [WIDTH-1:0]      mem_q [2**ADDR_WIDTH];
   logic                  we_d;
   logic [ADDR_WIDTH-1:0] waddr_d;
   logic [WIDTH-1:0]      wdata_d;

   always_comb begin
      we_d    = 1'b0;
      waddr_d = addr_i;
      wdata_d = d_i;
      if (clr_i) begin
         we_d    = 1'b1;
         waddr_d = clr_addr_i;
         wdata_d = INIT_VALUE;
      end else begin
         we_d = user_en_i & ~cen_i & ~gwen_i & ~wen_msb_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (we_d) begin
         mem_q[waddr_d] <= wdata_d;
      end
   end

   // Reading through the registered address gives write-first data and holds Q while idle.
   assign q_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ct_f_spsram_param.sv
// Parametrised single-port SRAM with clear sequencer and reset-defined output.
// Define CT_F_SPSRAM_OREG_EN to add an output pipeline register (read latency 2).
module ct_f_spsram_param
   import ct_f_spsram_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 9,
   parameter int unsigned           DATA_WIDTH  = 59,
   parameter int unsigned           SLICE_WIDTH = 29,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
   input logic               CLK,
   input logic               RSTN,
   ct_f_spsram_param_if.slave bus
);

   localparam int unsigned NUM_SLICES = num_slices(DATA_WIDTH, SLICE_WIDTH);

   spsram_state_e         state_q;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  busy_q;
   logic                  clr_en_d;
   logic                  user_en_d;
   logic [DATA_WIDTH-1:0] raw_d;

   assign clr_en_d  = RSTN && (state_q == ST_CLEAR);
   assign user_en_d = RSTN && (state_q == ST_IDLE) && !bus.INIT_REQ;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         addr_q  <= '0;
         busy_q  <= 1'b1;
      end else begin
         unique case (state_q)
            ST_CLEAR: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == '1) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_IDLE: begin
               if (bus.INIT_REQ) begin
                  state_q <= ST_CLEAR;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end else if (!bus.CEN) begin
                  addr_q <= bus.A;
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
      localparam int unsigned LO = k * SLICE_WIDTH;
      localparam int unsigned HI = slice_msb(k, DATA_WIDTH, SLICE_WIDTH);

      ct_f_spsram_slice #(
         .ADDR_WIDTH (ADDR_WIDTH),
         .WIDTH      (HI - LO + 1),
         .INIT_VALUE (INIT_VALUE[HI:LO])
      ) u_slice (
         .clk_i      (CLK),
         .clr_i      (clr_en_d),
         .clr_addr_i (cnt_q),
         .user_en_i  (user_en_d),
         .cen_i      (bus.CEN),
         .gwen_i     (bus.GWEN),
         .wen_msb_i  (bus.WEN[HI]),
         .addr_i     (bus.A),
         .d_i        (bus.D[HI:LO]),
         .rd_addr_i  (addr_q),
         .q_o        (raw_d[HI:LO])
      );
   end

   assign bus.INIT_BUSY = busy_q;

`ifdef CT_F_SPSRAM_OREG_EN
   logic                  acc_q;
   logic [DATA_WIDTH-1:0] oreg_q;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         acc_q  <= 1'b0;
         oreg_q <= '0;
      end else begin
         acc_q <= user_en_d && !bus.CEN;
         if (busy_q) begin
            oreg_q <= '0;
         end else if (acc_q) begin
            oreg_q <= raw_d;
         end
      end
   end

   // Mask also covers the first busy cycle, when oreg_q may still hold a pre-clear read.
   assign bus.Q = busy_q ? '0 : oreg_q;
`else
   assign bus.Q = busy_q ? '0 : raw_d;
`endif

endmodule

// File: tb/tb_ct_f_spsram_param.sv
// Randomised self-checking bench for ct_f_spsram_param against an array-based reference model.
module tb_ct_f_spsram_param;
   import ct_f_spsram_pkg::*;

   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 59;
   localparam int unsigned SW    = 29;
   localparam int unsigned DEPTH = 1 << AW;
   localparam logic [DW-1:0] INIT = 59'h0123_4567_89AB_CDEF;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   ct_f_spsram_param_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ct_f_spsram_param #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .SLICE_WIDTH (SW),
      .INIT_VALUE  (INIT)
   ) dut (
      .CLK  (clk),
      .RSTN (rstn),
      .bus  (bus)
   );

   int unsigned total = 0;
   int unsigned bad   = 0;

   // Reference model state
   logic [DW-1:0] m_mem [DEPTH];
   logic          m_busy;
   logic          m_acc;
   int unsigned   m_cnt;
   logic [AW-1:0] m_hold;
   logic [DW-1:0] m_oreg;
   logic [DW-1:0] exp_q;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rnd_word();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   function automatic void model_edge();
      logic [DW-1:0] raw_pre;
      logic          acc_now;
      int unsigned   lo;
      int unsigned   hi;
      raw_pre = m_mem[m_hold];
      if (!rstn) begin
         m_busy = 1'b1;
         m_cnt  = 0;
         m_hold = '0;
         m_acc  = 1'b0;
         m_oreg = '0;
      end else begin
         m_oreg  = m_busy ? '0 : (m_acc ? raw_pre : m_oreg);
         acc_now = !m_busy && !bus.INIT_REQ && !bus.CEN;
         if (m_busy) begin
            m_mem[m_cnt] = INIT;
            if (m_cnt == DEPTH - 1) m_busy = 1'b0;
            m_cnt++;
         end else if (bus.INIT_REQ) begin
            m_busy = 1'b1;
            m_cnt  = 0;
         end else if (!bus.CEN) begin
            m_hold = bus.A;
            if (!bus.GWEN) begin
               for (int unsigned k = 0; k < (DW + SW - 1) / SW; k++) begin
                  lo = k * SW;
                  hi = (lo + SW > DW) ? DW - 1 : lo + SW - 1;
                  if (!bus.WEN[hi]) begin
                     for (int unsigned b = lo; b <= hi; b++) m_mem[bus.A][b] = bus.D[b];
                  end
               end
            end
         end
         m_acc = acc_now;
      end
      exp_q = m_busy ? '0 : ((RD_LATENCY == 2) ? m_oreg : m_mem[m_hold]);
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_eq("q", 64'(bus.Q), 64'(exp_q));
      check_eq("busy", 64'(bus.INIT_BUSY), 64'(m_busy));
   endtask

   task automatic drive(input logic [AW-1:0] a, input logic cen, input logic gwen,
                        input logic [DW-1:0] wen, input logic [DW-1:0] d, input logic req);
      bus.A        = a;
      bus.CEN      = cen;
      bus.GWEN     = gwen;
      bus.WEN      = wen;
      bus.D        = d;
      bus.INIT_REQ = req;
   endtask

   task automatic idle();
      drive(AW'($urandom()), 1'b1, 1'b1, rnd_word(), rnd_word(), 1'b0);
   endtask

   task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] wen, input logic [DW-1:0] d);
      drive(a, 1'b0, 1'b0, wen, d, 1'b0);
      step();
      idle();
   endtask

   // Leaves Q sampled exactly at the read latency.
   task automatic read(input logic [AW-1:0] a);
      drive(a, 1'b0, 1'b1, rnd_word(), rnd_word(), 1'b0);
      step();
      idle();
      repeat (RD_LATENCY - 1) step();
   endtask

   task automatic wait_clear(output int unsigned n);
      n = 0;
      do begin
         step();
         n++;
      end while (bus.INIT_BUSY && n < 100);
   endtask

   logic [DW-1:0] pat;
   logic [DW-1:0] wen;
   int unsigned   n;

   initial begin
      rstn = 1'b0;
      idle();
      repeat (3) step();
      check_eq("rst_q", 64'(bus.Q), 64'h0);
      check_eq("rst_busy", 64'(bus.INIT_BUSY), 64'h1);

      rstn = 1'b1;
      wait_clear(n);
      check_eq("clr_len", 64'(n), 64'(DEPTH));

      read(4'd5);
      check_eq("rd5_init", 64'(bus.Q), 64'(INIT));

      pat = 59'h5A5A_5A5A_5A5A_5A5;
      write(4'd3, '0, pat);
      read(4'd3);
      check_eq("rd3", 64'(bus.Q), 64'(pat));

      write(4'd7, '0, '0);
      wen     = '1;
      wen[58] = 1'b0;
      wen[28] = 1'b0;
      write(4'd7, wen, '1);
      read(4'd7);
      check_eq("rd7_partial", 64'(bus.Q), 64'({1'b1, 29'h0, 29'h1FFF_FFFF}));

      read(4'd3);
      for (int unsigned i = 0; i < 10; i++) begin
         bus.A = AW'(i);
         step();
         check_eq("hold", 64'(bus.Q), 64'(pat));
      end

      drive(4'd2, 1'b0, 1'b0, '0, rnd_word(), 1'b1);
      step();
      check_eq("req_busy", 64'(bus.INIT_BUSY), 64'h1);
      n = 0;
      do begin
         drive(AW'($urandom()), 1'($urandom()), 1'($urandom()), rnd_word(), rnd_word(), 1'($urandom()));
         step();
         n++;
      end while (bus.INIT_BUSY && n < 100);
      check_eq("req_clr_len", 64'(n), 64'(DEPTH));
      idle();
      read(4'd2);
      check_eq("rd2_dropped", 64'(bus.Q), 64'(INIT));

      drive(4'd0, 1'b1, 1'b1, '1, '0, 1'b1);
      step();
      idle();
      n = 0;
      while (m_cnt != 8 && n < 100) begin
         step();
         n++;
      end
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      wait_clear(n);
      check_eq("rst_mid_clr_len", 64'(n), 64'(DEPTH));

      for (int unsigned i = 0; i < 400; i++) begin
         drive(AW'($urandom()), ($urandom_range(0, 3) == 0), 1'($urandom()), rnd_word(), rnd_word(),
               ($urandom_range(0, 39) == 0));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

endmodule

// File: doc/ct_f_spsram_param.md
# ct_f_spsram_param

Parametrised single-port SRAM model for FPGA builds. It presents the standard CEN/GWEN/bit-WEN macro interface and splits the data word into `fpga_ram` slices of configurable width. It adds three behaviours over the fixed-size wrappers: a hardware clear sequencer, defined output values during reset/clear, and an optional output pipeline register. It is the drop-in replacement for all per-size `ct_f_spsram_*` wrappers in the cache, TLB and BHT arrays.

## Interface
Parameters:
- `ADDR_WIDTH`, 9: address bits; depth = 2^ADDR_WIDTH.
- `DATA_WIDTH`, 59: word width.
- `SLICE_WIDTH`, 29: width of each `fpga_ram` slice.
  - NUM_SLICES = ceil(DATA_WIDTH/SLICE_WIDTH).
  - Slice 0 holds the low bits; the top slice may be narrower.
- `INIT_VALUE`, 0: DATA_WIDTH-bit word written by the clear sequencer.

Ports:
- `CLK` in 1: sole clock; all state on its rising edge.
- `RSTN` in 1: reset; synchronous, active-low.
- `A` in ADDR_WIDTH: address.
- `CEN` in 1: chip enable, active-low.
- `GWEN` in 1: global write enable, active-low.
- `WEN` in DATA_WIDTH: bit write enables, active-low. Slice k is written when the WEN bit at slice k's MSB is low.
- `D` in DATA_WIDTH: write data.
- `INIT_REQ` in 1: one-cycle pulse that requests a full-array clear.
- `Q` out DATA_WIDTH: read data.
- `INIT_BUSY` out 1: high while the clear sequencer owns the array.

## Operation
- FSM states: CLEAR, IDLE.
  - RSTN low: state CLEAR, clear counter = 0, address-hold register = 0, INIT_BUSY = 1, Q = 0.
- CLEAR:
  - Each cycle, write INIT_VALUE to address = counter in every slice, then counter +1.
  - When counter = 2^ADDR_WIDTH−1 is written, go to IDLE.
  - Counter is ADDR_WIDTH bits wide; the terminal compare is on all-ones, with no wrap.
- IDLE: INIT_REQ = 1 → CLEAR with counter = 0. INIT_BUSY rises the next cycle.
- INIT_REQ has priority over a same-cycle access; that access is dropped.
- While INIT_BUSY = 1:
  - User accesses are ignored: no write, no address capture.
  - Q is forced to 0.
  - INIT_REQ is ignored.
- RSTN low mid-clear: the sweep restarts from address 0.
- Access (IDLE, CEN = 0): A is captured into the address-hold register.
  - GWEN = 0: enabled slices write D.
  - Read returns write-first data per slice: new data for written slices, stored data for the others.
- CEN = 1: the RAM is addressed from the hold register, so Q holds the last read word indefinitely.
- GWEN = 1 with CEN = 0: pure read; WEN is ignored.

## Timing
- Without OREG: Q is valid after the edge that samples CEN = 0 (1-cycle latency).
- With OREG: Q is valid one edge later (2-cycle latency).
- Clear duration: RSTN sampled high at edge 0 → writes on edges 1..2^ADDR_WIDTH.
  - INIT_BUSY falls after edge 2^ADDR_WIDTH.
  - First user access is accepted on edge 2^ADDR_WIDTH+1.
- Back-to-back accesses every cycle are supported with no bubbles.
- Reset values: Q = 0, INIT_BUSY = 1 (then held through the clear).

## Configuration
- `CT_F_SPSRAM_OREG_EN` defined:
  - Adds a DATA_WIDTH output register that loads every cycle the previous cycle was an accepted access.
  - The register resets to 0 and is cleared to 0 while INIT_BUSY = 1.
  - Read latency is 2.
- Undefined: Q is driven from the slice outputs through the INIT_BUSY zero-mask; read latency is 1.

## Structure
- Package `ct_f_spsram_pkg`:
  - FSM state encoding (CLEAR, IDLE).
  - Function `num_slices(DATA_WIDTH, SLICE_WIDTH)`.
  - Function `slice_msb(k)`.
  - Read-latency constant selected by the macro.
- Sub-module `ct_f_spsram_slice`:
  - Wraps one `fpga_ram` with the write-enable decode (CEN, GWEN, WEN MSB, clear override) and the din mux (D vs INIT_VALUE slice).
  - Instantiated NUM_SLICES times in a generate loop, with the top slice width computed.

## Test plan
- Reset then idle, ADDR_WIDTH = 4:
  - INIT_BUSY = 1 for exactly 16 cycles and Q = 0 throughout.
  - A read of addr 5 afterwards returns INIT_VALUE.
- Write D = 59'h5A5A_5A5A_5A5A_5A5 to addr 3 with all WEN = 0, then read addr 3:
  - Q = the same value, at latency 1 (2 with OREG).
- Write addr 7 with WEN[58] = 0, WEN[57] = 1, WEN[28] = 0, D = all-ones, over stored 0:
  - Q = {1'b1, 29'h0, 29'h1FFF_FFFF}.
- Read addr 3, then CEN = 1 for 10 cycles with A toggling:
  - Q stays at addr 3's data.
- INIT_REQ together with a CEN = 0, GWEN = 0 write to addr 2:
  - The write is dropped.
  - After the clear, addr 2 reads INIT_VALUE.
- RSTN low for 1 cycle at counter = 8:
  - The clear restarts at 0.
  - INIT_BUSY falls 2^ADDR_WIDTH cycles after the reset release.
